// File: rtl/doorlock_pkg.sv
// rtl/doorlock_pkg.sv - shared state encoding and digit constants for the door lock
package doorlock_pkg;

    localparam int         DIGIT_W   = 4;
    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef enum logic [2:0] {
        ST_ENTRY,
        ST_CHECK,
        ST_UNLOCKED,
        ST_PROGRAM,
        ST_LOCKOUT
    } state_t;

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter with a done flag
//   clk  : system clock
//   rstn : asynchronous active-low reset
//   load : loads CYCLES-1 so the owning state lasts exactly CYCLES cycles
//   done : high while the count is zero
module cycle_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic load,
    output logic done
);

    localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES - 1);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/passcode_checker.sv
// rtl/passcode_checker.sv - keypad code entry, verification, reprogramming and optional lockout
//   clk, rstn     : clock, asynchronous active-low reset
//   key_valid     : digit strobe, key_digit (0-9 accepted, above 9 ignored)
//   key_clear     : discard partial entry (aborts PROGRAM)
//   set_mode      : enter PROGRAM, honoured only while unlocked
//   shuffle_init  : one-cycle keypad reshuffle request
//   unlock        : door release, fail_pulse : one-cycle mismatch pulse
//   locked_out    : lockout active, prog_active : PROGRAM active
//   digit_count   : digits accepted in the current entry
//   Macro PASSCODE_LOCKOUT_EN enables the fail counter and LOCKOUT state.
module passcode_checker
    import doorlock_pkg::*;
#(
    parameter int                     CODE_LEN       = 4,
    parameter logic [CODE_LEN*4-1:0]  DEFAULT_CODE   = 16'h1234,
    parameter int                     UNLOCK_CYCLES  = 1000,
    parameter int                     MAX_FAIL       = 3,
    parameter int                     LOCKOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       key_clear,
    input  logic       set_mode,
    output logic       shuffle_init,
    output logic       unlock,
    output logic       fail_pulse,
    output logic       locked_out,
    output logic       prog_active,
    output logic [2:0] digit_count
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;

    state_t              state;
    logic [CODE_W-1:0]   entry_buf;
    logic [CODE_W-1:0]   stored_code;
    logic [CODE_W-1:0]   shifted;
    logic                started;
    logic                key_ok;
    logic                last_digit;
    logic                code_match;
    logic                unlock_load;
    logic                unlock_done;

    always_comb begin
        key_ok      = key_valid && (key_digit <= DIGIT_MAX);
        shifted     = (entry_buf << DIGIT_W) | CODE_W'(key_digit);
        last_digit  = (digit_count == 3'(CODE_LEN - 1));
        code_match  = (entry_buf == stored_code);
        unlock_load = (state == ST_CHECK) && code_match;
    end

    cycle_timer #(.CYCLES(UNLOCK_CYCLES)) u_unlock_timer (
        .clk  (clk),
        .rstn (rstn),
        .load (unlock_load),
        .done (unlock_done)
    );

`ifdef PASSCODE_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic [FAIL_W-1:0] fail_cnt;
    logic [FAIL_W-1:0] fail_next;
    logic              fail_limit;
    logic              lock_load;
    logic              lock_done;

    always_comb begin
        fail_next  = fail_cnt + 1'b1;
        fail_limit = (fail_next >= FAIL_W'(MAX_FAIL));
        lock_load  = (state == ST_CHECK) && !code_match && fail_limit;
    end

    cycle_timer #(.CYCLES(LOCKOUT_CYCLES)) u_lock_timer (
        .clk  (clk),
        .rstn (rstn),
        .load (lock_load),
        .done (lock_done)
    );
`else
    localparam int unused_cfg = MAX_FAIL + LOCKOUT_CYCLES;

    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state        <= ST_ENTRY;
            entry_buf    <= '0;
            stored_code  <= DEFAULT_CODE;
            digit_count  <= '0;
            started      <= 1'b0;
            shuffle_init <= 1'b0;
            unlock       <= 1'b0;
            fail_pulse   <= 1'b0;
            prog_active  <= 1'b0;
`ifdef PASSCODE_LOCKOUT_EN
            fail_cnt     <= '0;
            locked_out   <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; the first post-reset cycle requests a shuffle.
            shuffle_init <= !started;
            started      <= 1'b1;
            fail_pulse   <= 1'b0;

            case (state)
                ST_ENTRY: begin
                    // Clear has priority over a digit arriving in the same cycle.
                    if (key_clear) begin
                        entry_buf    <= '0;
                        digit_count  <= '0;
                        shuffle_init <= 1'b1;
                    end else if (key_ok) begin
                        entry_buf   <= shifted;
                        digit_count <= digit_count + 3'd1;
                        if (last_digit) begin
                            state <= ST_CHECK;
                        end
                    end
                end

                ST_CHECK: begin
                    entry_buf   <= '0;
                    digit_count <= '0;
                    if (code_match) begin
                        state  <= ST_UNLOCKED;
                        unlock <= 1'b1;
`ifdef PASSCODE_LOCKOUT_EN
                        fail_cnt <= '0;
`endif
                    end else begin
                        fail_pulse <= 1'b1;
`ifdef PASSCODE_LOCKOUT_EN
                        fail_cnt <= fail_next;
                        if (fail_limit) begin
                            state      <= ST_LOCKOUT;
                            locked_out <= 1'b1;
                        end else begin
                            state        <= ST_ENTRY;
                            shuffle_init <= 1'b1;
                        end
`else
                        state        <= ST_ENTRY;
                        shuffle_init <= 1'b1;
`endif
                    end
                end

                ST_UNLOCKED: begin
                    if (set_mode) begin
                        state        <= ST_PROGRAM;
                        unlock       <= 1'b0;
                        prog_active  <= 1'b1;
                        shuffle_init <= 1'b1;
                        entry_buf    <= '0;
                        digit_count  <= '0;
                    end else if (unlock_done) begin
                        state        <= ST_ENTRY;
                        unlock       <= 1'b0;
                        shuffle_init <= 1'b1;
                    end
                end

                ST_PROGRAM: begin
                    if (key_clear) begin
                        state        <= ST_ENTRY;
                        prog_active  <= 1'b0;
                        shuffle_init <= 1'b1;
                        entry_buf    <= '0;
                        digit_count  <= '0;
                    end else if (key_ok) begin
                        if (last_digit) begin
                            stored_code  <= shifted;
                            state        <= ST_ENTRY;
                            prog_active  <= 1'b0;
                            shuffle_init <= 1'b1;
                            entry_buf    <= '0;
                            digit_count  <= '0;
                        end else begin
                            entry_buf   <= shifted;
                            digit_count <= digit_count + 3'd1;
                        end
                    end
                end

`ifdef PASSCODE_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (lock_done) begin
                        state        <= ST_ENTRY;
                        fail_cnt     <= '0;
                        locked_out   <= 1'b0;
                        shuffle_init <= 1'b1;
                    end
                end
`endif

                default: begin
                    state <= ST_ENTRY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_passcode_checker.sv
// tb/tb_passcode_checker.sv - directed self-checking bench for passcode_checker
module tb_passcode_checker;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       key_clear = 1'b0;
    logic       set_mode = 1'b0;
    logic       shuffle_init;
    logic       unlock;
    logic       fail_pulse;
    logic       locked_out;
    logic       prog_active;
    logic [2:0] digit_count;

    int n_checks = 0;
    int n_errors = 0;

    passcode_checker dut (
        .clk          (clk),
        .rstn         (rstn),
        .key_valid    (key_valid),
        .key_digit    (key_digit),
        .key_clear    (key_clear),
        .set_mode     (set_mode),
        .shuffle_init (shuffle_init),
        .unlock       (unlock),
        .fail_pulse   (fail_pulse),
        .locked_out   (locked_out),
        .prog_active  (prog_active),
        .digit_count  (digit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk);
        key_valid = 1'b1;
        key_digit = d;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] c);
        for (int i = 3; i >= 0; i--) begin
            press(c[i*4 +: 4]);
        end
    endtask

    // Returns one cycle after the CHECK state, where the result is visible.
    task automatic try_code(input logic [15:0] c, input logic good, input string tag);
        enter_code(c);
        @(negedge clk);
        check({tag, "_unlock"}, 32'(unlock), 32'(good));
        check({tag, "_fail"}, 32'(fail_pulse), 32'(!good));
        check({tag, "_cnt"}, 32'(digit_count), 32'd0);
    endtask

    task automatic hold_unlock(input string tag);
        int n = 0;
        while (unlock === 1'b1 && n < 3000) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_len"}, n, 1000);
        check({tag, "_shuf"}, 32'(shuffle_init), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_shuf"}, 32'(shuffle_init), 32'd0);
        check({tag, "_unlock"}, 32'(unlock), 32'd0);
        check({tag, "_fail"}, 32'(fail_pulse), 32'd0);
        check({tag, "_lock"}, 32'(locked_out), 32'd0);
        check({tag, "_prog"}, 32'(prog_active), 32'd0);
        check({tag, "_cnt"}, 32'(digit_count), 32'd0);
    endtask

    initial begin
        int fails;

        // Reset state and the boot-time shuffle request
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rstn = 1'b1;
        @(negedge clk);
        check("boot_shuf", 32'(shuffle_init), 32'd1);
        @(negedge clk);
        check("boot_shuf_end", 32'(shuffle_init), 32'd0);

        // Correct default code, two-cycle latency, 1000-cycle unlock
        press(4'd1);
        press(4'd2);
        check("t1_cnt2", 32'(digit_count), 32'd2);
        press(4'd3);
        press(4'd4);
        check("t1_check_unlock", 32'(unlock), 32'd0);
        @(negedge clk);
        check("t1_unlock", 32'(unlock), 32'd1);
        hold_unlock("t1");

        // Wrong code
        fails = 0;
        try_code(16'h1235, 1'b0, "t2a");
        check("t2a_shuf", 32'(shuffle_init), 32'd1);
        if (fail_pulse === 1'b1) fails++;
        @(negedge clk);
        check("t2a_pulse_end", 32'(fail_pulse), 32'd0);

`ifdef PASSCODE_LOCKOUT_EN
        begin
            int         n;
            logic       saw_unlock;
            logic [3:0] seq [4];
            seq = '{4'd1, 4'd2, 4'd3, 4'd4};
            try_code(16'h1235, 1'b0, "t2b");
            check("t2b_lock", 32'(locked_out), 32'd0);
            try_code(16'h1235, 1'b0, "t2c");
            check("t2c_lock", 32'(locked_out), 32'd1);
            n = 0;
            saw_unlock = 1'b0;
            while (locked_out === 1'b1 && n < 6000) begin
                n++;
                key_valid = (n >= 2 && n <= 8 && (n % 2) == 0);
                if (key_valid) key_digit = seq[n/2 - 1];
                if (unlock !== 1'b0) saw_unlock = 1'b1;
                @(negedge clk);
            end
            key_valid = 1'b0;
            check("t2_lock_len", n, 5000);
            check("t2_lock_unlock", 32'(saw_unlock), 32'd0);
            check("t2_lock_exit_shuf", 32'(shuffle_init), 32'd1);
            try_code(16'h1234, 1'b1, "t2_after");
            hold_unlock("t2_after");
        end
`else
        for (int i = 0; i < 4; i++) begin
            try_code(16'h1235, 1'b0, "t3");
            if (fail_pulse === 1'b1) fails++;
            check("t3_lock", 32'(locked_out), 32'd0);
        end
        check("t3_fail_total", fails, 5);
        try_code(16'h1234, 1'b1, "t3_after");
        hold_unlock("t3_after");
`endif

        // Clear together with a digit: clear wins
        press(4'd1);
        press(4'd2);
        check("t4_cnt2", 32'(digit_count), 32'd2);
        @(negedge clk);
        key_valid = 1'b1;
        key_digit = 4'd3;
        key_clear = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        key_clear = 1'b0;
        check("t4_cnt0", 32'(digit_count), 32'd0);
        check("t4_shuf", 32'(shuffle_init), 32'd1);
        try_code(16'h1234, 1'b1, "t4");
        hold_unlock("t4");

        // Reprogramming
        try_code(16'h1234, 1'b1, "t5a");
        @(negedge clk);
        set_mode = 1'b1;
        @(negedge clk);
        set_mode = 1'b0;
        check("t5_set_unlock", 32'(unlock), 32'd0);
        check("t5_set_prog", 32'(prog_active), 32'd1);
        check("t5_set_shuf", 32'(shuffle_init), 32'd1);
        enter_code(16'h9876);
        check("t5_prog_done", 32'(prog_active), 32'd0);
        check("t5_prog_cnt", 32'(digit_count), 32'd0);
        check("t5_prog_shuf", 32'(shuffle_init), 32'd1);
        try_code(16'h1234, 1'b0, "t5_old");
        try_code(16'h9876, 1'b1, "t5_new");
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_all_zero("t5_rst");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        try_code(16'h1234, 1'b1, "t5_default");

        // Invalid digits and reset during entry
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        press(4'd1);
        press(4'hA);
        check("t6_digit_a", 32'(digit_count), 32'd1);
        press(4'hF);
        check("t6_digit_f", 32'(digit_count), 32'd1);
        press(4'd2);
        check("t6_cnt2", 32'(digit_count), 32'd2);
        #2 rstn = 1'b0;
        #1 check_all_zero("t6_rst");
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/passcode_checker.md
# passcode_checker

Digit-entry and verification stage directly downstream of the shuffled keypad display register. It receives decoded digits (the display register's `data_out`) qualified by a press strobe and accumulates a fixed-length code. It compares the code against a stored passcode and drives the door-unlock output. It also requests a fresh keypad shuffle whenever a new entry begins, and optionally enforces a lockout after repeated failures.

## Interface
Parameters:
- `CODE_LEN`, default 4: number of digits per code, legal range 1–7.
- `DEFAULT_CODE`, default `16'h1234`: reset passcode, `CODE_LEN*4` bits, one BCD nibble per digit, first-entered digit in the MS nibble.
- `UNLOCK_CYCLES`, default 1000: cycles that `unlock` stays high.
- `MAX_FAIL`, default 3: consecutive failures that trigger lockout.
- `LOCKOUT_CYCLES`, default 5000: lockout duration in cycles.

Ports:
- `clk`  in  1: system clock; all logic updates on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `key_valid`  in  1: one-cycle strobe; `key_digit` is valid in that cycle.
- `key_digit`  in  4: digit value from the display register; values above 9 are ignored.
- `key_clear`  in  1: one-cycle strobe that discards the partial entry.
- `set_mode`  in  1: one-cycle strobe; honoured only in UNLOCKED.
- `shuffle_init`  out  1: one-cycle pulse that requests a keypad reshuffle.
- `unlock`  out  1: door-release drive.
- `fail_pulse`  out  1: one-cycle pulse on a mismatch.
- `locked_out`  out  1: high while in LOCKOUT.
- `prog_active`  out  1: high while in PROGRAM.
- `digit_count`  out  3: number of digits accepted in the current entry.

## Operation
- States: ENTRY, CHECK, UNLOCKED, PROGRAM, LOCKOUT.
- **ENTRY**
  - A digit is accepted when `key_valid`=1 and `key_digit`<=9.
  - An accepted digit shifts into the entry buffer; `digit_count` increments.
  - On the `CODE_LEN`-th accepted digit, next state is CHECK.
- **CHECK** (one cycle)
  - Match: go to UNLOCKED; clear the fail counter.
  - Mismatch: pulse `fail_pulse`; increment the fail counter. If the counter reaches `MAX_FAIL`, go to LOCKOUT; otherwise go to ENTRY.
- **UNLOCKED**
  - `unlock`=1; timer counts `UNLOCK_CYCLES`, then the block goes to ENTRY.
  - `set_mode` goes to PROGRAM; `unlock` drops in the same transition.
  - Keys are ignored.
- **PROGRAM**
  - Collects `CODE_LEN` digits, accepted as in ENTRY.
  - On the last digit, the stored code is replaced, `digit_count` clears, and the block goes to ENTRY.
- **LOCKOUT**
  - `locked_out`=1; all keys, `key_clear` and `set_mode` are ignored.
  - After `LOCKOUT_CYCLES`, the fail counter clears and the block goes to ENTRY.
- `key_clear` in ENTRY: zeroes `digit_count` and the buffer; the state is unchanged.
- `key_clear` in PROGRAM: aborts to ENTRY and keeps the old code.
- `key_clear` in the same cycle as `key_valid`: clear wins and the digit is dropped.
- `shuffle_init` pulses:
  - in the first cycle after `rstn` deasserts;
  - on every entry into ENTRY;
  - on every entry into PROGRAM;
  - on every in-ENTRY clear.
  - Pulses never exceed one cycle, even when these events coincide.
- The stored code persists across all states and returns to `DEFAULT_CODE` only on reset.

## Timing
- Reset values: `shuffle_init`=0, `unlock`=0, `fail_pulse`=0, `locked_out`=0, `prog_active`=0, `digit_count`=0, state=ENTRY, stored code=`DEFAULT_CODE`, fail counter=0.
- Digit accepted at edge k → `digit_count` updated after edge k.
- Last digit at edge k → CHECK during k..k+1 → `unlock` or `fail_pulse` high after edge k+1, giving 2-cycle result latency.
- `unlock` is high for exactly `UNLOCK_CYCLES` cycles unless `set_mode` shortens it.
- `locked_out` is high for exactly `LOCKOUT_CYCLES` cycles.
- `shuffle_init` is registered and asserts in the first cycle of the destination state.
- Timers are `$clog2` of their parameter wide; they are loaded on state entry and count down to zero.
- Asserting `rstn` mid-operation forces all reset values immediately; the partially entered code and any new code are lost.

## Configuration
- Macro `PASSCODE_LOCKOUT_EN`.
- Defined: the fail counter, the LOCKOUT state and the `MAX_FAIL`/`LOCKOUT_CYCLES` behaviour are present.
- Undefined:
  - the fail counter and LOCKOUT logic are removed;
  - `locked_out` is tied to 0;
  - a mismatch always returns to ENTRY with `fail_pulse`;
  - the parameters are accepted but unused.

## Structure
- Shared package `doorlock_pkg` holds:
  - the state enum (ENTRY/CHECK/UNLOCKED/PROGRAM/LOCKOUT);
  - the digit-width constant (4);
  - the invalid-digit threshold (9).
- Sub-module `cycle_timer`: a loadable down-counter with a `done` flag.
  - Instance 1: unlock duration.
  - Instance 2: lockout duration, present only under `PASSCODE_LOCKOUT_EN`.

## Test plan
1. Reset release → `shuffle_init` pulses once; enter 1,2,3,4 → `unlock`=1 two cycles after the last key and stays high exactly 1000 cycles, then `shuffle_init` pulses.
2. Enter 1,2,3,5 → one `fail_pulse`, `digit_count`=0, `unlock` stays 0; 3 such failures with the macro → `locked_out`=1 for 5000 cycles, during which 1,2,3,4 is ignored.
3. Without `PASSCODE_LOCKOUT_EN`, 5 wrong codes → 5 `fail_pulse`, `locked_out` never 1; then 1,2,3,4 → unlock.
4. Enter 1,2, then `key_clear` together with `key_valid`=3 → `digit_count`=0 and `shuffle_init` pulses; then 1,2,3,4 → unlock.
5. Unlock, `set_mode`, enter 9,8,7,6 → `prog_active` drops and the state is ENTRY; 1,2,3,4 fails; 9,8,7,6 unlocks; reset → 1,2,3,4 unlocks again.
6. `key_digit`=4'hA/4'hF with `key_valid` → ignored, `digit_count` unchanged; `rstn` low mid-entry → all outputs 0 immediately.
